// File: rtl/surf_dout_align.sv
// -----------------------------------------------------------------------------
// surf_dout_align
//
// Word-alignment controller sitting right after the SURF COUT/DOUT receive PHY.
// Watches the 8-bit deserialized DOUT word, pulses the DOUT ISERDES bitslip
// until TRAIN_PATTERN has been seen LOCK_COUNT times in a row, then forwards
// the registered word with a valid flag to the TURFIO DOUT capture logic.
//
// Optional build macro: SURF_DOUT_ALIGN_MISMATCH_CNT_EN
//    defined   : mismatch_count_o is a 16-bit saturating count of CHECK-state
//                mismatches, cleared by reset and start_i
//    undefined : mismatch_count_o is tied to zero
//
// Ports
//    sysclk_i          system clock (PHY CLKDIV domain)
//    rst_n_i           synchronous active-low reset
//    start_i           one-cycle pulse, (re)starts training from any state
//    dout_i[7:0]       deserialized DOUT word
//    bitslip_o         one-cycle bitslip pulse to the DOUT ISERDES
//    locked_o          alignment achieved
//    fail_o            no alignment found in any of the 8 slip positions
//    busy_o            training in progress
//    slip_count_o[2:0] bitslips issued since the last start
//    data_o[7:0]       dout_i delayed by one cycle
//    valid_o           data_o is valid (tracks locked_o)
//    mismatch_count_o  training mismatch counter (see macro above)
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start_i, all outputs low
// CHECK  | comparing dout_i against TRAIN_PATTERN, counting matches
// SLIP   | bitslip_o high for this single cycle
// WAIT   | letting the ISERDES settle after a slip, no compares
// LOCKED | aligned, data_o forwarded with valid_o
// FAIL   | all 8 slip positions tried without a lock
// -----------------------------------------------------------------------------
module surf_dout_align #(
   parameter logic [7:0]  TRAIN_PATTERN = 8'hA6,
   parameter int unsigned LOCK_COUNT    = 16,
   parameter int unsigned SLIP_WAIT     = 4
) (
   input  logic        sysclk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic [7:0]  dout_i,
   output logic        bitslip_o,
   output logic        locked_o,
   output logic        fail_o,
   output logic        busy_o,
   output logic [2:0]  slip_count_o,
   output logic [7:0]  data_o,
   output logic        valid_o,
   output logic [15:0] mismatch_count_o
);

   localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 1);
   localparam logic [3:0] WAIT_LOAD = 4'(SLIP_WAIT - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_SLIP   = 3'd2,
      ST_WAIT   = 3'd3,
      ST_LOCKED = 3'd4,
      ST_FAIL   = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_match;
   logic [7:0]  r_match_cnt;
   logic [3:0]  r_wait_cnt;
   logic [2:0]  r_slip_cnt;
   logic        r_bitslip;
   logic        r_locked;
   logic        r_fail;
   logic        r_busy;
   logic        r_valid;
   logic [7:0]  r_data;

   assign w_match = (dout_i == TRAIN_PATTERN);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   w_state_nxt = ST_IDLE;
         ST_CHECK: begin
            if (w_match) begin
               if (r_match_cnt == LOCK_LAST) w_state_nxt = ST_LOCKED;
            end else if (r_slip_cnt == 3'd7) begin
               w_state_nxt = ST_FAIL;
            end else begin
               w_state_nxt = ST_SLIP;
            end
         end
         ST_SLIP:   w_state_nxt = ST_WAIT;
         ST_WAIT:   if (r_wait_cnt == 4'd0) w_state_nxt = ST_CHECK;
         ST_LOCKED: w_state_nxt = ST_LOCKED;
         ST_FAIL:   w_state_nxt = ST_FAIL;
         default:   w_state_nxt = ST_IDLE;
      endcase
      // start_i overrides every other transition
      if (start_i) w_state_nxt = ST_CHECK;
   end

   // Outputs are registered from the next state so they line up with the
   // state they describe (locked_o and valid_o rise on the locking edge).
   always_ff @(posedge sysclk_i) begin
      if (!rst_n_i) begin
         r_state     <= ST_IDLE;
         r_match_cnt <= 8'd0;
         r_wait_cnt  <= 4'd0;
         r_slip_cnt  <= 3'd0;
         r_bitslip   <= 1'b0;
         r_locked    <= 1'b0;
         r_fail      <= 1'b0;
         r_busy      <= 1'b0;
         r_valid     <= 1'b0;
         r_data      <= 8'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_data    <= dout_i;
         r_bitslip <= (w_state_nxt == ST_SLIP);
         r_locked  <= (w_state_nxt == ST_LOCKED);
         r_valid   <= (w_state_nxt == ST_LOCKED);
         r_fail    <= (w_state_nxt == ST_FAIL);
         r_busy    <= (w_state_nxt == ST_CHECK) || (w_state_nxt == ST_SLIP) ||
                      (w_state_nxt == ST_WAIT);
         if (start_i) begin
            r_match_cnt <= 8'd0;
            r_wait_cnt  <= 4'd0;
            r_slip_cnt  <= 3'd0;
         end else begin
            case (r_state)
               ST_CHECK: begin
                  if (w_match) r_match_cnt <= r_match_cnt + 8'd1;
                  else         r_match_cnt <= 8'd0;
               end
               ST_SLIP: begin
                  // never wraps: CHECK diverts to FAIL once this reaches 7
                  r_slip_cnt <= r_slip_cnt + 3'd1;
                  r_wait_cnt <= WAIT_LOAD;
               end
               ST_WAIT: begin
                  if (r_wait_cnt != 4'd0) r_wait_cnt <= r_wait_cnt - 4'd1;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef SURF_DOUT_ALIGN_MISMATCH_CNT_EN
   logic [15:0] r_mismatch_cnt;

   always_ff @(posedge sysclk_i) begin
      if (!rst_n_i) begin
         r_mismatch_cnt <= 16'd0;
      end else if (start_i) begin
         r_mismatch_cnt <= 16'd0;
      end else if ((r_state == ST_CHECK) && !w_match &&
                   (r_mismatch_cnt != 16'hFFFF)) begin
         r_mismatch_cnt <= r_mismatch_cnt + 16'd1;
      end
   end

   assign mismatch_count_o = r_mismatch_cnt;
`else
   assign mismatch_count_o = 16'h0000;
`endif

   assign bitslip_o    = r_bitslip;
   assign locked_o     = r_locked;
   assign fail_o       = r_fail;
   assign busy_o       = r_busy;
   assign slip_count_o = r_slip_cnt;
   assign data_o       = r_data;
   assign valid_o      = r_valid;

endmodule
